// File: rtl/unstripe_ctrl.sv
// Two-lane unstriper: aligns lane_0/lane_1 valids, then emits words alternating lanes at 2x rate.
// Latency 1 cycle in RUN; no backpressure, lane misalignment is counted and forces realignment.
module unstripe_ctrl #(
  parameter logic        START_LANE = 1'b0,
  parameter int unsigned ALIGN_CNT  = 4
) (
  input  logic        clk_2f,
  input  logic        reset,
  input  logic [31:0] lane_0,
  input  logic [31:0] lane_1,
  input  logic        valid_0,
  input  logic        valid_1,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        sel,
  output logic [1:0]  state,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALIGN = 2'd1,
    S_RUN   = 2'd2,
    S_ERR   = 2'd3
  } state_e;

  localparam logic [3:0] ALIGN_CNT_L = 4'(ALIGN_CNT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sel_q, sel_d;
  logic [31:0] data_q, data_d;
  logic        vld_q, vld_d;
  logic [7:0]  err_q, err_d;

  logic both_vld, mism_vld;
  assign both_vld = valid_0 & valid_1;
  assign mism_vld = valid_0 ^ valid_1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = START_LANE;
    data_d  = data_q;
    vld_d   = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (both_vld) begin
          state_d = S_ALIGN;
          cnt_d   = 4'd1;
        end
      end
      S_ALIGN: begin
        // Once the streak has reached the target, RUN follows regardless of this cycle's valids.
        if (cnt_q == ALIGN_CNT_L) begin
          state_d = S_RUN;
          cnt_d   = 4'd0;
        end else if (both_vld) begin
          cnt_d = cnt_q + 4'd1;
        end else if (mism_vld) begin
          cnt_d = 4'd0;
        end else begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      end
      S_RUN: begin
        if (both_vld) begin
          data_d = sel_q ? lane_1 : lane_0;
          vld_d  = 1'b1;
          sel_d  = ~sel_q;
        end else if (mism_vld) begin
          state_d = S_ERR;
          err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        state_d = S_ALIGN;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      sel_q   <= START_LANE;
      data_q  <= 32'd0;
      vld_q   <= 1'b0;
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = vld_q;
  assign sel       = sel_q;
  assign state     = state_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_unstripe_ctrl.sv
// Scoreboard bench for unstripe_ctrl: two instances (START_LANE 0 and 1) driven with identical
// directed + random lane traffic, checked every cycle against a lane-position reference model.
module tb_unstripe_ctrl;

  localparam int ALIGN_N = 4;
  localparam int M_IDLE = 0, M_ALIGN = 1, M_RUN = 2, M_ERR = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lane_0, lane_1;
  logic        valid_0, valid_1;

  logic [31:0] dout [2];
  logic        vout [2];
  logic        selo [2];
  logic [1:0]  sto  [2];
  logic [7:0]  errc [2];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int st;
    int sl;
    int vo;
    int ec;
  } exp_t;

  exp_t        sq [2][$];
  logic [31:0] dq [2][$];

  // Reference model state, one set per instance.
  int          m_mode   [2];
  int          m_streak [2];
  int          m_words  [2];
  int          m_errs   [2];
  int          m_vo     [2];

  always #5 clk = ~clk;

  unstripe_ctrl #(.START_LANE(1'b0), .ALIGN_CNT(ALIGN_N)) dut0 (
    .clk_2f(clk), .reset(rst), .lane_0(lane_0), .lane_1(lane_1),
    .valid_0(valid_0), .valid_1(valid_1), .data_out(dout[0]), .valid_out(vout[0]),
    .sel(selo[0]), .state(sto[0]), .err_cnt(errc[0]));

  unstripe_ctrl #(.START_LANE(1'b1), .ALIGN_CNT(ALIGN_N)) dut1 (
    .clk_2f(clk), .reset(rst), .lane_0(lane_0), .lane_1(lane_1),
    .valid_0(valid_0), .valid_1(valid_1), .data_out(dout[1]), .valid_out(vout[1]),
    .sel(selo[1]), .state(sto[1]), .err_cnt(errc[1]));

  task automatic check(input string name, input int k, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Model: words are taken from lane (start + words emitted so far in this run) mod 2.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      int   lane;
      if (rst) begin
        m_mode[k] = M_IDLE; m_streak[k] = 0; m_words[k] = 0; m_errs[k] = 0; m_vo[k] = 0;
      end else begin
        m_vo[k] = 0;
        case (m_mode[k])
          M_IDLE: if (valid_0 && valid_1) begin m_mode[k] = M_ALIGN; m_streak[k] = 1; end
          M_ALIGN: begin
            if (m_streak[k] == ALIGN_N) begin m_mode[k] = M_RUN; m_words[k] = 0; end
            else if (valid_0 && valid_1) m_streak[k]++;
            else if (valid_0 != valid_1) m_streak[k] = 0;
            else begin m_mode[k] = M_IDLE; m_streak[k] = 0; end
          end
          M_RUN: begin
            lane = (k + m_words[k]) % 2;
            if (valid_0 && valid_1) begin
              m_vo[k] = 1;
              dq[k].push_back(lane == 1 ? lane_1 : lane_0);
              m_words[k]++;
            end else if (valid_0 != valid_1) begin
              m_mode[k] = M_ERR;
              if (m_errs[k] < 255) m_errs[k]++;
            end else begin
              m_mode[k] = M_IDLE;
            end
          end
          default: begin m_mode[k] = M_ALIGN; m_streak[k] = 0; end
        endcase
      end
      e.st = m_mode[k];
      e.sl = (m_mode[k] == M_RUN) ? (k + m_words[k]) % 2 : k;
      e.vo = m_vo[k];
      e.ec = m_errs[k];
      sq[k].push_back(e);
    end
  end

  // Monitor: status every cycle, data words whenever valid_out is high.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      if (sq[k].size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL status_underflow inst%0d: got empty queue expected an entry", k);
      end else begin
        e = sq[k].pop_front();
        check("state", k, sto[k], e.st);
        check("sel", k, selo[k], e.sl);
        check("valid_out", k, vout[k], e.vo);
        check("err_cnt", k, errc[k], e.ec);
      end
      if (vout[k] === 1'b1) begin
        if (dq[k].size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL data_unexpected inst%0d: got 0x%0h expected no word", k, dout[k]);
        end else begin
          check("data_out", k, dout[k], dq[k].pop_front());
        end
      end
    end
  end

  task automatic drive(input logic r, input logic a, input logic b,
                       input logic [31:0] d0, input logic [31:0] d1);
    rst = r; valid_0 = a; valid_1 = b; lane_0 = d0; lane_1 = d1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(input logic r, input logic a, input logic b);
    drive(r, a, b, $urandom, $urandom);
  endtask

  initial begin
    rst = 1'b1; valid_0 = 1'b0; valid_1 = 1'b0; lane_0 = '0; lane_1 = '0;

    drive_rand(1, 0, 0);
    drive_rand(1, 0, 0);

    // Continuous matched traffic with recognisable lane patterns.
    for (int n = 0; n < 14; n++)
      drive(0, 1, 1, 32'hAAAA0000 + n, 32'hBBBB0000 + n);

    // One-cycle lane_1 dropout in RUN, then recovery.
    drive_rand(0, 1, 0);
    for (int n = 0; n < 10; n++) drive_rand(0, 1, 1);

    // Back to IDLE, then a broken alignment streak.
    drive_rand(0, 0, 0);
    drive_rand(0, 0, 0);
    for (int n = 0; n < 3; n++) drive_rand(0, 1, 1);
    drive_rand(0, 1, 0);
    for (int n = 0; n < 8; n++) drive_rand(0, 1, 1);

    // Low pair on the non-boundary RUN cycle.
    drive_rand(0, 0, 0);
    for (int n = 0; n < 7; n++) drive_rand(0, 1, 1);
    drive_rand(0, 0, 0);

    // 300 misalignment events to saturate err_cnt.
    for (int n = 0; n < 8; n++) drive_rand(0, 1, 1);
    for (int ev = 0; ev < 300; ev++) begin
      if (ev % 2 == 0) drive_rand(0, 1, 0); else drive_rand(0, 0, 1);
      for (int n = 0; n < 6; n++) drive_rand(0, 1, 1);
    end
    @(negedge clk); #1;
    check("err_cnt_saturated", 0, errc[0], 255);
    check("err_cnt_saturated", 1, errc[1], 255);

    // Randomised traffic, mostly matched, with occasional resets.
    for (int n = 0; n < 500; n++) begin
      int p;
      logic r;
      p = $urandom_range(0, 19);
      r = ($urandom_range(0, 99) < 2);
      if (p < 15)      drive_rand(r, 1, 1);
      else if (p < 17) drive_rand(r, 0, 0);
      else if (p < 18) drive_rand(r, 1, 0);
      else             drive_rand(r, 0, 1);
    end

    // Reset while streaming, then restart to see the first word's lane.
    drive_rand(1, 0, 0);
    for (int n = 0; n < 9; n++) drive_rand(0, 1, 1);
    drive_rand(1, 1, 1);
    @(negedge clk); #1;
    check("reset_data_out", 0, dout[0], 0);
    check("reset_data_out", 1, dout[1], 0);
    for (int n = 0; n < 9; n++)
      drive(0, 1, 1, 32'hAAAA0100 + n, 32'hBBBB0100 + n);
    drive_rand(0, 0, 0);

    @(negedge clk); #1;
    for (int k = 0; k < 2; k++)
      check("leftover_words", k, dq[k].size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/unstripe_ctrl.md
UNSTRIPE_CTRL -- requirements
Module: unstripe_ctrl

Interface
REQ-001 Parameter START_LANE, default 0: lane selected first in every RUN slot (0 = lane_0, 1 = lane_1).
REQ-002 Parameter ALIGN_CNT, default 4: consecutive matched-valid cycles required to leave ALIGN; legal range 1..15.
REQ-003 Port clk_2f, input, 1: single clock; all logic rising-edge on clk_2f.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port lane_0, input, 32: data word from lane 0.
REQ-006 Port lane_1, input, 32: data word from lane 1.
REQ-007 Port valid_0, input, 1: lane_0 word valid.
REQ-008 Port valid_1, input, 1: lane_1 word valid.
REQ-009 Port data_out, output, 32: registered unstriped word.
REQ-010 Port valid_out, output, 1: data_out valid.
REQ-011 Port sel, output, 1: current lane select (0 = lane_0, 1 = lane_1); registered.
REQ-012 Port state, output, 2: FSM state; IDLE=0, ALIGN=1, RUN=2, ERR=3.
REQ-013 Port err_cnt, output, 8: count of misalignment events, saturating.

Function
REQ-014 FSM in IDLE: sel held at START_LANE, valid_out=0; both valid_0 and valid_1 high -> ALIGN with align counter loaded to 1.
REQ-015 FSM in ALIGN, valid_0=valid_1=1: align counter +1; reaching ALIGN_CNT -> RUN next cycle with sel=START_LANE.
REQ-016 FSM in ALIGN, valid_0!=valid_1: align counter cleared to 0; FSM stays in ALIGN.
REQ-017 FSM in ALIGN, both valids low: -> IDLE; align counter cleared.
REQ-018 No data emitted in IDLE, ALIGN or ERR: valid_out=0, data_out holds its last value.
REQ-019 FSM in RUN: sel toggles every clk_2f cycle; slot boundary = cycle with sel==START_LANE.
REQ-020 FSM in RUN, valid_0=valid_1=1: data_out <= (sel ? lane_1 : lane_0) and valid_out <= 1 on the next edge; latency 1 cycle.
REQ-021 FSM in RUN, both valids low at a slot boundary: -> IDLE, valid_out=0; a low pair on the non-boundary cycle also forces the same transition (no partial slot emitted).
REQ-022 FSM in RUN, valid_0!=valid_1 on any cycle: -> ERR; that word is not emitted (valid_out=0).
REQ-023 ERR lasts exactly 1 cycle: err_cnt +1 saturating at 255; then -> ALIGN with counter 0; sel reset to START_LANE.
REQ-024 Simultaneous ERR entry and err_cnt=255: err_cnt stays 255, FSM still passes through ERR.
REQ-025 Output order in RUN for START_LANE=0: lane_0 word, lane_1 word, lane_0 word, ...; for START_LANE=1 reversed.
REQ-026 err_cnt cleared only by reset; IDLE does not clear it.

Reset
REQ-027 reset high at an edge: state=IDLE, sel=START_LANE, data_out=0, valid_out=0, err_cnt=0, align counter=0.
REQ-028 reset dominates all other inputs, including mid-RUN and mid-ERR; first post-reset cycle obeys REQ-014.
REQ-029 No output changes between edges; reset deasserted has no effect until the next edge.

Verification
REQ-030 Reset 2 cycles, valids low -> state=0, data_out=0, valid_out=0, err_cnt=0, sel=0.
REQ-031 Both valids high from cycle 0; lane_0=0xAAAA0000+n, lane_1=0xBBBB0000+n -> state=1 for 4 cycles, then 2; valid_out rises 1 cycle after RUN entry; data_out alternates lane_0/lane_1 values sampled the prior cycle.
REQ-032 In ALIGN after 3 matched cycles, drop valid_1 for 1 cycle -> counter restarts; RUN reached only after 4 further matched cycles.
REQ-033 In RUN, valid_1=0 for one cycle -> state=3 next cycle, err_cnt=1, valid_out=0, then state=1, sel=0.
REQ-034 Force 300 misalignment events -> err_cnt saturates at 255, never wraps to 0.
REQ-035 Assert reset mid-RUN with valid_out=1 -> next edge all outputs at REQ-027 values; repeat with START_LANE=1 -> first emitted word is from lane_1.
